// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and limits for the sequential multiplier
//
// Purpose: the multiplier state encoding and its legal operand width range.
// Ports:   none (package).
package mult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mult_state_e;

  localparam int MULT_MIN_WIDTH = 2;
  localparam int MULT_MAX_WIDTH = 32;

endpackage : mult_pkg

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-and-add multiplier, signed/unsigned, one bit per cycle
//
// Purpose: multiplies two WIDTH-bit operands over WIDTH+1 cycles. Signed mode
//          multiplies magnitudes and negates the product in a final fix-up step.
// Ports:
//   clk_i     in   1        clock, rising edge
//   rst_ni    in   1        asynchronous active-low reset
//   start_i   in   1        request, sampled in IDLE or DONE only
//   signed_i  in   1        operands are two's complement (sampled with start_i)
//   a_i       in   WIDTH    multiplicand (sampled with start_i)
//   b_i       in   WIDTH    multiplier (sampled with start_i)
//   busy_o    out  1        operation in progress (CALC or FIX)
//   valid_o   out  1        result_o holds the product (DONE)
//   result_o  out  2*WIDTH  product, zero whenever valid_o is low
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               valid_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;

  if (WIDTH < MULT_MIN_WIDTH || WIDTH > MULT_MAX_WIDTH) begin : g_width_check
    $error("seq_multiplier: WIDTH out of range 2..32");
  end

  // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             is_signed);
    return (is_signed && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  mult_state_e      state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d;
  logic [WIDTH-1:0] mag_b_q, mag_b_d;
  logic             neg_q, neg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    case (state_q)
      // DONE accepts a new request exactly like IDLE, with no bubble cycle.
      IDLE, DONE: begin
        if (start_i) begin
          mag_a_d = magnitude(a_i, signed_i);
          mag_b_d = magnitude(b_i, signed_i);
          neg_d   = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (mag_b_q[cnt_q]) begin
          acc_d = acc_q + (PW'(mag_a_q) << cnt_q);
        end
        cnt_d = cnt_q + CW'(1);
        // Explicit terminal compare: for power-of-two WIDTH the counter wraps.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (neg_q) begin
          acc_d = ~acc_q + PW'(1);
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o   = (state_q == CALC) || (state_q == FIX);
  assign valid_o  = (state_q == DONE);
  assign result_o = valid_o ? acc_q : '0;

endmodule : seq_multiplier
